// File: rtl/inst_queue.sv
// Purpose: fetch-to-decode instruction FIFO of {pc, inst} entries with fetch PC-advance strobe and flush.
// Latency: an entry pushed at edge N is presented to decode after edge N (no bypass path).
// Backpressure: a full queue refuses the push (next_fetch=0) even when decode pops in the same cycle.
module inst_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     IF_over,
    input  logic [63:0]              IF_ID_bus,
    output logic                     next_fetch,
    input  logic                     flush,
    input  logic                     ID_allow_in,
    output logic                     ID_valid,
    output logic [63:0]              ID_bus,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Entry storage is deliberately left unreset; only pointers and count define validity.
    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Handshake decode: full-check uses only registered count so next_fetch never depends on ID_allow_in.
    always_comb begin
        full       = (count_q == FULL_CNT);
        empty      = (count_q == '0);
        push       = IF_over & ~full & ~flush;
        next_fetch = push | flush;
        ID_valid   = ~empty & ~flush;
        pop        = ID_valid & ID_allow_in;
        ID_bus     = ID_valid ? mem_q[head_q] : 64'h0;
        count      = count_q;
    end

    // Next-state for pointers and occupancy; flush wins over any push or pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers, cleared asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry write at the tail slot on an accepted fetch.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= IF_ID_bus;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        resetn;
    logic        IF_over;
    logic [63:0] IF_ID_bus;
    logic        next_fetch;
    logic        flush;
    logic        ID_allow_in;
    logic        ID_valid;
    logic [63:0] ID_bus;
    logic [2:0]  count;

    int n_cmp;
    int n_err;

    logic [63:0] q[$];

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .IF_over    (IF_over),
        .IF_ID_bus  (IF_ID_bus),
        .next_fetch (next_fetch),
        .flush      (flush),
        .ID_allow_in(ID_allow_in),
        .ID_valid   (ID_valid),
        .ID_bus     (ID_bus),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs just after the falling edge; outputs are then sampled mid-cycle.
    task automatic drive(input logic ifo, input logic [63:0] bus, input logic fl, input logic allow);
        @(negedge clk);
        IF_over     = ifo;
        IF_ID_bus   = bus;
        flush       = fl;
        ID_allow_in = allow;
        #1;
    endtask

    // Advance one rising edge and update the reference queue from the rules of the block.
    task automatic step();
        int sz    = q.size();
        bit do_po = (sz > 0) && !flush && ID_allow_in;
        bit do_pu = IF_over && (sz < DEPTH) && !flush;
        logic [63:0] b = IF_ID_bus;
        @(posedge clk);
        if (!resetn || flush) begin
            q.delete();
        end else begin
            if (do_po) void'(q.pop_front());
            if (do_pu) q.push_back(b);
        end
    endtask

    function automatic logic [63:0] mk(input logic [31:0] pc);
        return {pc, $urandom()};
    endfunction

    task automatic test_reset();
        resetn = 1'b0; IF_over = 1'b0; IF_ID_bus = '0; flush = 1'b0; ID_allow_in = 1'b0;
        #13;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_cmp++; if (ID_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", ID_valid); end
        n_cmp++; if (ID_bus !== 64'h0) begin n_err++; $display("FAIL reset_bus got=%h exp=0", ID_bus); end
        n_cmp++; if (next_fetch !== 1'b0) begin n_err++; $display("FAIL reset_next_fetch got=%b exp=0", next_fetch); end
        @(negedge clk);
        resetn = 1'b1;
        q.delete();
    endtask

    logic [63:0] saved [4];

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            saved[i] = mk(32'hbfc00000 + 32'(4 * i));
            drive(1'b1, saved[i], 1'b0, 1'b0);
            n_cmp++; if (next_fetch !== 1'b1) begin n_err++; $display("FAIL fill_nf[%0d] got=%b exp=1", i, next_fetch); end
            n_cmp++; if (count !== 3'(i)) begin n_err++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i); end
            n_cmp++; if (ID_valid !== (i != 0)) begin n_err++; $display("FAIL fill_valid[%0d] got=%b exp=%b", i, ID_valid, i != 0); end
            step();
        end
        drive(1'b1, mk(32'hbfc00010), 1'b0, 1'b0);
        n_cmp++; if (next_fetch !== 1'b0) begin n_err++; $display("FAIL fill_full_nf got=%b exp=0", next_fetch); end
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_full_count got=%0d exp=4", count); end
        n_cmp++; if (ID_bus !== saved[0]) begin n_err++; $display("FAIL fill_head got=%h exp=%h", ID_bus, saved[0]); end
        step();
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 64'h0, 1'b0, 1'b1);
            n_cmp++; if (ID_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, ID_valid); end
            n_cmp++; if (ID_bus !== saved[i]) begin n_err++; $display("FAIL drain_bus[%0d] got=%h exp=%h", i, ID_bus, saved[i]); end
            step();
        end
        drive(1'b0, 64'h0, 1'b0, 1'b1);
        n_cmp++; if (ID_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty_valid got=%b exp=0", ID_valid); end
        n_cmp++; if (ID_bus !== 64'h0) begin n_err++; $display("FAIL drain_empty_bus got=%h exp=0", ID_bus); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL drain_empty_count got=%0d exp=0", count); end
        step();
    endtask

    task automatic test_stream_wrap();
        logic [63:0] e [10];
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                e[i] = mk(32'h80000000 + 32'(4 * i));
                drive(1'b1, e[i], 1'b0, 1'b1);
                n_cmp++; if (next_fetch !== 1'b1) begin n_err++; $display("FAIL stream_nf[%0d] got=%b exp=1", i, next_fetch); end
            end else begin
                drive(1'b0, 64'h0, 1'b0, 1'b1);
            end
            if (i > 0) begin
                n_cmp++; if (ID_bus !== e[i-1]) begin n_err++; $display("FAIL stream_bus[%0d] got=%h exp=%h", i, ID_bus, e[i-1]); end
                n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL stream_count[%0d] got=%0d exp=1", i, count); end
            end
            step();
        end
    endtask

    task automatic test_full_pop();
        logic [63:0] x;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, mk(32'h1000 + 32'(4 * i)), 1'b0, 1'b0);
            step();
        end
        x = mk(32'h2000);
        drive(1'b1, x, 1'b0, 1'b1);
        n_cmp++; if (next_fetch !== 1'b0) begin n_err++; $display("FAIL fullpop_nf got=%b exp=0", next_fetch); end
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fullpop_count got=%0d exp=4", count); end
        step();
        drive(1'b1, x, 1'b0, 1'b1);
        n_cmp++; if (next_fetch !== 1'b1) begin n_err++; $display("FAIL fullpop_retry_nf got=%b exp=1", next_fetch); end
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL fullpop_after_count got=%0d exp=3", count); end
        step();
        drive(1'b0, 64'h0, 1'b0, 1'b1);
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL fullpop_pushpop_count got=%0d exp=3", count); end
        step();
    endtask

    task automatic test_flush();
        logic [63:0] f = {32'hdeadbeef, 32'h12345678};
        drive(1'b1, f, 1'b1, 1'b1);
        n_cmp++; if (next_fetch !== 1'b1) begin n_err++; $display("FAIL flush_nf got=%b exp=1", next_fetch); end
        n_cmp++; if (ID_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got=%b exp=0", ID_valid); end
        n_cmp++; if (ID_bus !== 64'h0) begin n_err++; $display("FAIL flush_bus got=%h exp=0", ID_bus); end
        step();
        drive(1'b0, 64'h0, 1'b1, 1'b1);
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_count got=%0d exp=0", count); end
        n_cmp++; if (next_fetch !== 1'b1) begin n_err++; $display("FAIL flush_empty_nf got=%b exp=1", next_fetch); end
        step();
        drive(1'b0, 64'h0, 1'b0, 1'b1);
        n_cmp++; if (ID_valid !== 1'b0 || ID_bus[63:32] === 32'hdeadbeef) begin n_err++; $display("FAIL flush_leak valid=%b bus=%h exp valid=0", ID_valid, ID_bus); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_empty_count got=%0d exp=0", count); end
        step();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk(32'h3000 + 32'(4 * i)), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL arst_pre_count got=%0d exp=3", count); end
        resetn = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL arst_count got=%0d exp=0", count); end
        n_cmp++; if (ID_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got=%b exp=0", ID_valid); end
        q.delete();
        @(negedge clk);
        resetn = 1'b1;
        drive(1'b1, mk(32'h4000), 1'b0, 1'b0);
        n_cmp++; if (next_fetch !== 1'b1) begin n_err++; $display("FAIL arst_first_nf got=%b exp=1", next_fetch); end
        step();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL arst_first_count got=%0d exp=1", count); end
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic        ifo = ($urandom_range(99) < 70);
            logic        fl  = ($urandom_range(99) < 5);
            logic        al  = ($urandom_range(99) < 55);
            logic        e_v;
            logic [63:0] e_b;
            logic        e_nf;
            drive(ifo, {$urandom(), $urandom()}, fl, al);
            e_v  = (q.size() > 0) && !fl;
            e_b  = e_v ? q[0] : 64'h0;
            e_nf = fl || (ifo && q.size() < DEPTH);
            n_cmp++; if (ID_valid !== e_v) begin n_err++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, ID_valid, e_v); end
            n_cmp++; if (ID_bus !== e_b) begin n_err++; $display("FAIL rnd_bus[%0d] got=%h exp=%h", i, ID_bus, e_b); end
            n_cmp++; if (next_fetch !== e_nf) begin n_err++; $display("FAIL rnd_nf[%0d] got=%b exp=%b", i, next_fetch, e_nf); end
            n_cmp++; if (count !== 3'(q.size())) begin n_err++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, count, q.size()); end
            step();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_fill();
        test_drain();
        test_stream_wrap();
        test_full_pop();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction queue between the fetch stage and the decode stage of the five-stage pipeline. It captures each completed fetch as a {pc, inst} entry, buffers up to DEPTH entries, and presents them in order to decode under a valid/allow-in handshake. It also generates the fetch stage's PC-advance strobe, which decouples fetch from decode stalls. A flush from a taken jump/branch or an exception empties the queue and redirects fetch in the same cycle.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- clk  input  1  clock; all state updates on rising edge
- resetn  input  1  reset, asynchronous, active-low
- IF_over  input  1  fetch stage has a valid {pc, inst} on IF_ID_bus this cycle
- IF_ID_bus  input  64  {pc[31:0], inst[31:0]} from fetch
- next_fetch  output  1  fetch may latch its next PC (entry accepted, or redirect)
- flush  input  1  jump/branch taken or exception valid; discard all queued and in-flight entries
- ID_allow_in  input  1  decode accepts an entry this cycle
- ID_valid  output  1  head entry valid for decode
- ID_bus  output  64  head entry {pc, inst}; all zeros when ID_valid=0
- count  output  log2(DEPTH)+1  number of valid entries

## Operation
- Storage: DEPTH×64-bit array, head and tail pointers of log2(DEPTH) bits, and a count register of log2(DEPTH)+1 bits. Pointers wrap naturally modulo DEPTH.
- full = (count == DEPTH); empty = (count == 0).
- push = IF_over & !full & !flush. On push, write IF_ID_bus at tail, then tail+1.
- pop = ID_valid & ID_allow_in. On pop, head+1.
- count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- next_fetch = push | flush, combinational.
  - A refused entry (full) holds fetch. IF_over stays high and the same entry is offered again.
  - On flush, fetch loads the redirect PC.
- ID_valid = !empty & !flush. ID_bus = head entry when ID_valid, else 64'h0.
- Flush has highest priority:
  - head, tail and count go to 0 next edge.
  - No push and no pop occur in the flush cycle.
  - The IF_over entry in that cycle is discarded.
- Delay-slot ordering is the producer's responsibility. flush is raised only after the delay-slot instruction has been popped to decode.
- No bypass: a pushed entry is visible at ID_bus from the next cycle.
- Full with simultaneous pop: push is still refused; the freed slot is usable next cycle. This keeps next_fetch free of any ID_allow_in path.
- Array contents are not reset; pointers and count are.

## Timing
- Asynchronous reset (resetn=0): head=tail=0, count=0 immediately.
  - Therefore ID_valid=0 and ID_bus=0.
  - next_fetch=0 while IF_over=0, which holds because fetch also resets.
- Enqueue-to-visible latency: 1 cycle. An entry pushed at edge N has ID_valid=1 after edge N.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Reset deasserted mid-stream: the queue starts empty; the first IF_over after release is accepted in that cycle.
- Flush while empty: next_fetch=1; state is unchanged (already zero).
- Flush while full: all DEPTH entries are dropped; count=0 next cycle.
- Tail wrap from DEPTH−1 to 0 and head wrap behave identically to mid-range indices.

## Test plan
- Reset then fill: IF_over=1 with pcs 0xbfc00000, 04, 08, 0c and ID_allow_in=0 -> next_fetch high for 4 cycles, then low; count=4; ID_bus={0xbfc00000, inst0}.
- Drain in order: from full, ID_allow_in=1 for 4 cycles -> ID_bus pcs 0xbfc00000, 04, 08, 0c on consecutive cycles; then ID_valid=0, ID_bus=0, count=0.
- Streaming with wrap: 10 consecutive pushes with ID_allow_in=1 -> each entry appears one cycle after push; count stays 1; pcs in order across the pointer wrap.
- Full with pop: count=4, IF_over=1, ID_allow_in=1 -> next_fetch=0 that cycle, count=3; next cycle the push is accepted and count=3 (push+pop).
- Flush with pending push: count=2, IF_over=1, flush=1 -> next_fetch=1, ID_valid=0 that cycle; next cycle count=0; the flushed pc never appears on ID_bus.
- Async reset mid-operation: count=3, resetn pulled low between edges -> count=0 and ID_valid=0 without waiting for a clock edge.
